// File: rtl/mask_unit_read_scheduler_if.sv
// Job, crossbar request and response bundle of the mask-unit read scheduler.
// The slave side is the scheduler; the master side is the control FSM plus crossbar.
interface mask_unit_read_scheduler_if #(
   parameter int ELEM_W = 11
);
   logic              job_valid;
   logic              job_ready;
   logic [4:0]        job_vs;
   logic [1:0]        job_eew;
   logic [ELEM_W-1:0] job_count;
   logic [3:0]        rd_valid;
   logic [3:0]        rd_ready;
   logic [19:0]       rd_vs;
   logic [27:0]       rd_offset;
   logic [7:0]        rd_readLane;
   logic [7:0]        rd_dataOffset;
   logic [3:0]        resp_valid;

   modport master (
      output job_valid, job_vs, job_eew, job_count,
      output rd_ready, resp_valid,
      input  job_ready, rd_valid, rd_vs, rd_offset,
      input  rd_readLane, rd_dataOffset
   );

   modport slave (
      input  job_valid, job_vs, job_eew, job_count,
      input  rd_ready, resp_valid,
      output job_ready, rd_valid, rd_vs, rd_offset,
      output rd_readLane, rd_dataOffset
   );
endinterface

// File: rtl/mask_unit_read_scheduler.sv
// Expands one gather job into per-slot element reads on the 4 crossbar inputs.
// Optional MASK_UNIT_READ_SCHED_PERF_EN adds stall/request perf counters.
module mask_unit_read_scheduler #(
   parameter int ELEM_W  = 11,
   parameter int MAX_OUT = 4
) (
   input  logic clock,
   input  logic reset,
   mask_unit_read_scheduler_if.slave bus,
   output logic busy,
   output logic done,
   output logic err
`ifdef MASK_UNIT_READ_SCHED_PERF_EN
   ,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_reqs
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   localparam int IW = ELEM_W + 1;
   localparam int BW = ELEM_W + 2;

   stateT             state;
   stateT             stateNxt;
   logic [4:0]        jobVs;
   logic [1:0]        jobEew;
   logic [ELEM_W-1:0] jobCount;
   logic [IW-1:0]     idx    [4];
   logic [IW-1:0]     idxNxt [4];
   logic [3:0]        outCnt [4];
   logic [3:0]        outNxt [4];
   logic [BW-1:0]     b      [4];
   logic [3:0]        rdValid;
   logic [3:0]        fire;
   logic              errSet;
   logic              allDone;
   logic              accept;

   assign accept        = (state == IDLE) & bus.job_valid;
   assign bus.job_ready = (state == IDLE);
   assign bus.rd_valid  = rdValid;
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   always_comb begin
      rdValid           = '0;
      fire              = '0;
      errSet            = 1'b0;
      allDone           = 1'b1;
      bus.rd_vs         = '0;
      bus.rd_offset     = '0;
      bus.rd_readLane   = '0;
      bus.rd_dataOffset = '0;
      for (int k = 0; k < 4; k++) begin
         b[k] = BW'(idx[k][ELEM_W-1:0]) << jobEew;
         rdValid[k] = (state == RUN)
                    && (idx[k] < {1'b0, jobCount})
                    && (outCnt[k] < 4'(MAX_OUT));
         fire[k] = rdValid[k] & bus.rd_ready[k];
         idxNxt[k] = fire[k] ? idx[k] + IW'(4) : idx[k];
         outNxt[k] = outCnt[k];
         unique case ({fire[k], bus.resp_valid[k]})
            2'b10: outNxt[k] = outCnt[k] + 4'd1;
            2'b01: begin
               if (outCnt[k] == 4'd0) errSet = 1'b1;
               else outNxt[k] = outCnt[k] - 4'd1;
            end
            default: outNxt[k] = outCnt[k];
         endcase
         allDone = allDone
                 && (idxNxt[k] >= {1'b0, jobCount})
                 && (outNxt[k] == 4'd0);
         bus.rd_dataOffset[2*k +: 2] = b[k][1:0];
         bus.rd_readLane[2*k +: 2]   = b[k][3:2];
         bus.rd_offset[7*k +: 7]     = b[k][10:4];
         bus.rd_vs[5*k +: 5]         = jobVs + 5'(b[k][BW-1:11]);
      end
   end

   always_comb begin
      stateNxt = state;
      unique case (state)
         IDLE: begin
            if (bus.job_valid)
               stateNxt = (bus.job_count == '0) ? DONE : RUN;
         end
         RUN:     if (allDone) stateNxt = DONE;
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         jobVs    <= '0;
         jobEew   <= '0;
         jobCount <= '0;
         err      <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            idx[k]    <= '0;
            outCnt[k] <= '0;
         end
      end else begin
         state <= stateNxt;
         if (errSet) err <= 1'b1;
         if (accept) begin
            jobVs    <= bus.job_vs;
            jobEew   <= (bus.job_eew == 2'd3) ? 2'd2 : bus.job_eew;
            jobCount <= bus.job_count;
         end
         for (int k = 0; k < 4; k++) begin
            idx[k]    <= accept ? IW'(k) : idxNxt[k];
            outCnt[k] <= outNxt[k];
         end
      end
   end

`ifdef MASK_UNIT_READ_SCHED_PERF_EN
   logic [2:0]  fireCnt;
   logic [32:0] reqSum;
   logic        stall;

   assign fireCnt = 3'(fire[0]) + 3'(fire[1]) + 3'(fire[2]) + 3'(fire[3]);
   assign reqSum  = {1'b0, perf_reqs} + 33'(fireCnt);
   assign stall   = (state == RUN) && |(rdValid & ~bus.rd_ready);

   // Both counters saturate and survive job boundaries.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall <= '0;
         perf_reqs  <= '0;
      end else begin
         if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
         perf_reqs <= reqSum[32] ? '1 : reqSum[31:0];
      end
   end
`endif
endmodule

// File: tb/tb_mask_unit_read_scheduler.sv
// Bench for mask_unit_read_scheduler: two instances (MAX_OUT 4 and 2) against
// an element-level reference model, plus vector table and directed sequences.
module tb_mask_unit_read_scheduler;
   localparam int EW = 11;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic          jobValid = 1'b0;
   logic [4:0]    jobVs = '0;
   logic [1:0]    jobEew = '0;
   logic [EW-1:0] jobCount = '0;
   logic [3:0]    rdy  [2];
   logic [3:0]    resp [2];

   logic [3:0]  gValid [2];
   logic [19:0] gVs    [2];
   logic [27:0] gOff   [2];
   logic [7:0]  gLane  [2];
   logic [7:0]  gDoff  [2];
   logic        gReady [2];
   logic        gBusy  [2];
   logic        gDone  [2];
   logic        gErr   [2];
`ifdef MASK_UNIT_READ_SCHED_PERF_EN
   logic [31:0] pStall [2];
   logic [31:0] pReqs  [2];
`endif

   mask_unit_read_scheduler_if #(.ELEM_W(EW)) bus0 ();
   mask_unit_read_scheduler_if #(.ELEM_W(EW)) bus1 ();

   assign bus0.job_valid  = jobValid;
   assign bus0.job_vs     = jobVs;
   assign bus0.job_eew    = jobEew;
   assign bus0.job_count  = jobCount;
   assign bus0.rd_ready   = rdy[0];
   assign bus0.resp_valid = resp[0];
   assign bus1.job_valid  = jobValid;
   assign bus1.job_vs     = jobVs;
   assign bus1.job_eew    = jobEew;
   assign bus1.job_count  = jobCount;
   assign bus1.rd_ready   = rdy[1];
   assign bus1.resp_valid = resp[1];

   assign gValid[0] = bus0.rd_valid;
   assign gVs[0]    = bus0.rd_vs;
   assign gOff[0]   = bus0.rd_offset;
   assign gLane[0]  = bus0.rd_readLane;
   assign gDoff[0]  = bus0.rd_dataOffset;
   assign gReady[0] = bus0.job_ready;
   assign gValid[1] = bus1.rd_valid;
   assign gVs[1]    = bus1.rd_vs;
   assign gOff[1]   = bus1.rd_offset;
   assign gLane[1]  = bus1.rd_readLane;
   assign gDoff[1]  = bus1.rd_dataOffset;
   assign gReady[1] = bus1.job_ready;

   mask_unit_read_scheduler #(.ELEM_W(EW), .MAX_OUT(4)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0),
      .busy(gBusy[0]), .done(gDone[0]), .err(gErr[0])
`ifdef MASK_UNIT_READ_SCHED_PERF_EN
      , .perf_stall(pStall[0]), .perf_reqs(pReqs[0])
`endif
   );

   mask_unit_read_scheduler #(.ELEM_W(EW), .MAX_OUT(2)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1),
      .busy(gBusy[1]), .done(gDone[1]), .err(gErr[1])
`ifdef MASK_UNIT_READ_SCHED_PERF_EN
      , .perf_stall(pStall[1]), .perf_reqs(pReqs[1])
`endif
   );

   // Reference model: mState 0=idle 1=run 2=done; mNext = next element per slot.
   int       maxOut [2] = '{4, 2};
   int       mState [2];
   int       mNext  [2][4];
   int       mOut   [2][4];
   bit       mErr   [2];
   int       mVs    [2];
   int       mEew   [2];
   int       mCount [2];
   bit [3:0] mFire  [2];
   int       tests = 0;
   int       fails = 0;

   task automatic chk(string nm, int i, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s inst%0d: actual %0d, required %0d", nm, i, act, exp);
      end
   endtask

   task automatic modelReset(int i);
      mState[i] = 0; mErr[i] = 0; mVs[i] = 0; mEew[i] = 0;
      mCount[i] = 0; mFire[i] = '0;
      for (int k = 0; k < 4; k++) begin
         mNext[i][k] = 0;
         mOut[i][k]  = 0;
      end
   endtask

   function automatic bit [3:0] expValid(int i);
      bit [3:0] v = '0;
      for (int k = 0; k < 4; k++)
         v[k] = (mState[i] == 1) && (mNext[i][k] < mCount[i])
              && (mOut[i][k] < maxOut[i]);
      return v;
   endfunction

   task automatic stepCheck();
      bit [3:0] ev;
      int e, by;
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         ev = expValid(i);
         chk("job_ready", i, gReady[i], mState[i] == 0);
         chk("busy", i, gBusy[i], mState[i] != 0);
         chk("done", i, gDone[i], mState[i] == 2);
         chk("err", i, gErr[i], mErr[i]);
         chk("rd_valid", i, gValid[i], ev);
         for (int k = 0; k < 4; k++) begin
            if (ev[k]) begin
               e  = mNext[i][k];
               by = e * (1 << mEew[i]);
               chk("rd_dataOffset", i, gDoff[i][2*k +: 2], by % 4);
               chk("rd_readLane", i, gLane[i][2*k +: 2], (by / 4) % 4);
               chk("rd_offset", i, gOff[i][7*k +: 7], (by / 16) % 128);
               chk("rd_vs", i, gVs[i][5*k +: 5], (mVs[i] + by / 2048) % 32);
            end
         end
      end
   endtask

   task automatic stepAdvance();
      bit [3:0] fire;
      bit fin;
      for (int i = 0; i < 2; i++) begin
         if (reset) modelReset(i);
         else begin
            fire = expValid(i) & rdy[i];
            mFire[i] = fire;
            for (int k = 0; k < 4; k++) begin
               if (fire[k]) mNext[i][k] += 4;
               if (fire[k] && !resp[i][k]) mOut[i][k]++;
               else if (!fire[k] && resp[i][k]) begin
                  if (mOut[i][k] > 0) mOut[i][k]--;
                  else mErr[i] = 1;
               end
            end
            case (mState[i])
               0: if (jobValid) begin
                  mVs[i] = jobVs;
                  mEew[i] = (jobEew == 2'd3) ? 2 : int'(jobEew);
                  mCount[i] = jobCount;
                  for (int k = 0; k < 4; k++) mNext[i][k] = k;
                  mState[i] = (jobCount == 0) ? 2 : 1;
               end
               1: begin
                  fin = 1;
                  for (int k = 0; k < 4; k++)
                     if (mNext[i][k] < mCount[i] || mOut[i][k] != 0) fin = 0;
                  if (fin) mState[i] = 2;
               end
               default: mState[i] = 0;
            endcase
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic step();
      stepCheck();
      stepAdvance();
   endtask

   task automatic doReset();
      reset = 1'b1; jobValid = 1'b0;
      rdy = '{4'h0, 4'h0}; resp = '{4'h0, 4'h0};
      step();
      reset = 1'b0;
   endtask

   task automatic startJob(int vs, int eew, int cnt);
      jobVs = 5'(vs); jobEew = 2'(eew); jobCount = EW'(cnt);
      jobValid = 1'b1;
      rdy = '{4'h0, 4'h0}; resp = '{4'h0, 4'h0};
      step();
      jobValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!(mState[0] == 0 && mState[1] == 0) && n < 600) begin
         rdy = '{4'hF, 4'hF};
         for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) resp[i][k] = (mOut[i][k] > 0);
         step();
         n++;
      end
      resp = '{4'h0, 4'h0};
      chk("drain completes", 0, (mState[0] == 0 && mState[1] == 0), 1);
   endtask

   typedef struct {
      int vs; int eew; int count; int doneCyc;
      int lane1; int off1; int doff1; int vs1;
   } vecT;

   vecT tbl [5];
   int  doneAt [2];
   int  pulses [2];

   initial begin
      tbl[0] = '{3, 2, 8, 4, 1, 0, 0, 3};
      tbl[1] = '{0, 0, 5, 4, 0, 0, 1, 0};
      tbl[2] = '{7, 1, 13, 6, 0, 0, 2, 7};
      tbl[3] = '{9, 3, 2, 3, 1, 0, 0, 9};
      tbl[4] = '{21, 0, 0, 1, -1, 0, 0, 0};
      rdy = '{4'h0, 4'h0}; resp = '{4'h0, 4'h0};
      @(posedge clock);
      #1;
      modelReset(0); modelReset(1);
      doReset();

      // Full-ready jobs with each response returned one cycle after its fire.
      foreach (tbl[v]) begin
         startJob(tbl[v].vs, tbl[v].eew, tbl[v].count);
         doneAt = '{0, 0}; pulses = '{0, 0};
         for (int c = 1; c <= 12; c++) begin
            rdy = '{4'hF, 4'hF};
            resp = '{mFire[0], mFire[1]};
            stepCheck();
            if (c == 1 && tbl[v].lane1 >= 0)
               for (int i = 0; i < 2; i++) begin
                  chk("tbl slot1 lane", i, gLane[i][3:2], tbl[v].lane1);
                  chk("tbl slot1 offset", i, gOff[i][13:7], tbl[v].off1);
                  chk("tbl slot1 dOff", i, gDoff[i][3:2], tbl[v].doff1);
                  chk("tbl slot1 vs", i, gVs[i][9:5], tbl[v].vs1);
               end
            for (int i = 0; i < 2; i++)
               if (gDone[i] === 1'b1) begin
                  pulses[i]++;
                  if (doneAt[i] == 0) doneAt[i] = c;
               end
            stepAdvance();
         end
         for (int i = 0; i < 2; i++) begin
            chk("tbl done cycle", i, doneAt[i], tbl[v].doneCyc);
            chk("tbl done pulses", i, pulses[i], 1);
         end
      end

      // Only slot0 ready: slot0 reaches element 4, others hold stable.
      startJob(4, 0, 5);
      for (int c = 1; c <= 5; c++) begin
         rdy = '{4'h1, 4'h1};
         stepCheck();
         for (int i = 0; i < 2; i++) begin
            chk("hold slot1 dOff", i, gDoff[i][3:2], 1);
            chk("hold slot3 dOff", i, gDoff[i][7:6], 3);
            chk("hold slot2 vs", i, gVs[i][14:10], 4);
            if (c == 2) begin
               chk("elem4 lane", i, gLane[i][1:0], 1);
               chk("elem4 dOff", i, gDoff[i][1:0], 0);
            end
            if (c >= 3) chk("hold valid", i, gValid[i], 4'b1110);
         end
         stepAdvance();
      end
      drain();

      // Outstanding limit: MAX_OUT=2 instance stops after two fires per slot.
      startJob(0, 0, 40);
      rdy = '{4'hF, 4'hF};
      step();
      step();
      jobValid = 1'b1; jobCount = '0;
      stepCheck();
      chk("maxout stop", 1, gValid[1], 4'b0000);
      chk("maxout4 still", 0, gValid[0], 4'b1111);
      stepAdvance();
      jobValid = 1'b0;
      resp[1] = 4'b0100;
      step();
      resp[1] = 4'b0000;
      stepCheck();
      chk("maxout reenable", 1, gValid[1], 4'b0100);
      stepAdvance();
      drain();

      // Reset mid-run, then a stray response sets the sticky error.
      startJob(5, 1, 100);
      rdy = '{4'hF, 4'hF};
      repeat (5) step();
      doReset();
      stepCheck();
      chk("reset rd_valid", 0, gValid[0], 0);
      chk("reset job_ready", 0, gReady[0], 1);
      resp = '{4'h1, 4'h1};
      stepAdvance();
      resp = '{4'h0, 4'h0};
      stepCheck();
      chk("stray resp err", 0, gErr[0], 1);
      chk("stray resp err", 1, gErr[1], 1);
      stepAdvance();
      doReset();

      // Large job: element 512 crosses into the next vector register.
      startJob(31, 2, 1024);
      doneAt = '{0, 0};
      for (int c = 1; c <= 270; c++) begin
         rdy = '{4'hF, 4'hF};
         resp = '{mFire[0], mFire[1]};
         stepCheck();
         for (int i = 0; i < 2; i++) begin
            if (c == 129) begin
               chk("elem512 vs", i, gVs[i][4:0], 0);
               chk("elem512 offset", i, gOff[i][6:0], 0);
            end
            if (gDone[i] === 1'b1 && doneAt[i] == 0) begin
               doneAt[i] = c;
`ifdef MASK_UNIT_READ_SCHED_PERF_EN
               chk("perf_reqs", i, pReqs[i], 1024);
               chk("perf_stall", i, pStall[i], 0);
`endif
            end
         end
         stepAdvance();
      end
      for (int i = 0; i < 2; i++) chk("big done cycle", i, doneAt[i], 258);
      resp = '{4'h0, 4'h0};

      // Random jobs with random ready and legal random responses.
      for (int j = 0; j < 8; j++) begin
         int n = 0;
         startJob(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 60)));
         while (!(mState[0] == 0 && mState[1] == 0) && n < 3000) begin
            for (int i = 0; i < 2; i++) begin
               rdy[i] = 4'($urandom_range(0, 15));
               for (int k = 0; k < 4; k++)
                  resp[i][k] = (mOut[i][k] > 0) && ($urandom_range(0, 1) == 1);
            end
            step();
            n++;
         end
         resp = '{4'h0, 4'h0};
         chk("random job completes", j, (mState[0] == 0 && mState[1] == 0), 1);
      end
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
